// File: rtl/picorv_ahb_bridge.sv
// PicoRV32 native memory port to a single-transfer AHB master with a posted-write
// FIFO, strobe-driven byte/half/word sizing and two-cycle slave response handling.
module picorv_ahb_bridge #(
  parameter int WBUF_DEPTH = 2,
  parameter int HPROT_PRIV = 1,
  parameter int PARK_REQ   = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        HBUSREQ,
  input  logic        HGRANT,
  output logic        HLOCK,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);
  localparam int FD = (WBUF_DEPTH > 0) ? WBUF_DEPTH : 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_RESP2} state_t;
  state_t state_q, state_d;

  logic [29:0]   op_addr_q;
  logic [31:0]   op_wdata_q;
  logic [3:0]    op_strb_q;
  logic          op_split_q, op_write_q, op_instr_q, op_posted_q, resp_err_q;
  logic          mem_ready_q, bus_err_q;
  logic [31:0]   mem_rdata_q;
  logic [29:0]   fifo_addr_q [FD];
  logic [31:0]   fifo_data_q [FD];
  logic [3:0]    fifo_strb_q [FD];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [2:0] cur_size;
  logic [1:0] cur_off;
  logic [3:0] cur_mask;
  logic       last_sub, okay, fifo_nonempty, take_fifo, take_cpu;
  logic       op_done, err_done, push, pop;

  // Sub-word addressing comes from the strobes, so the low CPU address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  function automatic logic is_split(input logic [3:0] s);
    return !(s == 4'hf || s == 4'h3 || s == 4'hc || (s & (s - 4'd1)) == 4'h0);
  endfunction

  // Current sub-transfer: irregular patterns walk the set lanes one byte at a time.
  always_comb begin
    cur_size = 3'b010;
    cur_off  = 2'b00;
    cur_mask = 4'b1111;
    if (op_write_q && !op_split_q && op_strb_q == 4'b0011) begin
      cur_size = 3'b001;
      cur_mask = 4'b0011;
    end else if (op_write_q && !op_split_q && op_strb_q == 4'b1100) begin
      cur_size = 3'b001;
      cur_off  = 2'b10;
      cur_mask = 4'b1100;
    end else if (op_write_q && (op_split_q || op_strb_q != 4'b1111)) begin
      cur_size = 3'b000;
      if (op_strb_q[0]) begin
        cur_mask = 4'b0001;
      end else if (op_strb_q[1]) begin
        cur_off  = 2'b01;
        cur_mask = 4'b0010;
      end else if (op_strb_q[2]) begin
        cur_off  = 2'b10;
        cur_mask = 4'b0100;
      end else begin
        cur_off  = 2'b11;
        cur_mask = 4'b1000;
      end
    end
  end

  assign last_sub      = (op_strb_q & ~cur_mask) == 4'h0;
  assign okay          = (HRESP == 2'b00);
  assign fifo_nonempty = (count_q != '0);
  assign take_fifo     = (state_q == S_IDLE) && fifo_nonempty;
  assign take_cpu      = (state_q == S_IDLE) && !fifo_nonempty && mem_valid && !mem_ready_q &&
                         (mem_wstrb == 4'h0 || WBUF_DEPTH == 0);
  assign op_done       = (state_q == S_DATA) && HREADY && okay && last_sub;
  assign err_done      = (state_q == S_RESP2) && HREADY && resp_err_q;
  assign pop           = (op_done || err_done) && op_posted_q;
  // A full FIFO still accepts a write in the cycle its head retires.
  assign push          = (WBUF_DEPTH > 0) && mem_valid && (mem_wstrb != 4'h0) && !mem_ready_q &&
                         ((count_q != CW'(FD)) || pop);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take_fifo || take_cpu) state_d = S_REQ;
      S_REQ:   if (HGRANT && HREADY) state_d = S_ADDR;
      S_ADDR:  if (HREADY) state_d = S_DATA;
      S_DATA: begin
        if (HREADY && okay) state_d = last_sub ? S_IDLE : (HGRANT ? S_ADDR : S_REQ);
        else if (!HREADY && !okay) state_d = S_RESP2;
      end
      S_RESP2: if (HREADY) state_d = resp_err_q ? S_IDLE : S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    HBUSREQ = (state_q == S_REQ) || (state_q == S_ADDR) || ((state_q == S_DATA) && !last_sub) ||
              ((PARK_REQ != 0) && (fifo_nonempty || mem_valid));
    HLOCK   = 1'b0;
    HBURST  = 3'b000;
    HTRANS  = 2'b00;
    HADDR   = 32'h0;
    HWRITE  = 1'b0;
    HSIZE   = 3'b000;
    HPROT   = 4'h0;
    HWDATA  = 32'h0;
    if (state_q == S_ADDR) begin
      HTRANS = 2'b10;
      HADDR  = {op_addr_q, cur_off};
      HWRITE = op_write_q;
      HSIZE  = cur_size;
      HPROT  = {2'b00, (HPROT_PRIV != 0), ~op_instr_q};
    end
    if (state_q == S_DATA) HWDATA = op_wdata_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      op_addr_q   <= '0;
      op_wdata_q  <= '0;
      op_strb_q   <= '0;
      op_split_q  <= 1'b0;
      op_write_q  <= 1'b0;
      op_instr_q  <= 1'b0;
      op_posted_q <= 1'b0;
      resp_err_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (take_fifo) begin
        op_addr_q   <= fifo_addr_q[rd_ptr_q];
        op_wdata_q  <= fifo_data_q[rd_ptr_q];
        op_strb_q   <= fifo_strb_q[rd_ptr_q];
        op_split_q  <= is_split(fifo_strb_q[rd_ptr_q]);
        op_write_q  <= 1'b1;
        op_instr_q  <= 1'b0;
        op_posted_q <= 1'b1;
      end else if (take_cpu) begin
        op_addr_q   <= mem_addr[31:2];
        op_wdata_q  <= mem_wdata;
        op_strb_q   <= mem_wstrb;
        op_split_q  <= is_split(mem_wstrb);
        op_write_q  <= (mem_wstrb != 4'h0);
        op_instr_q  <= mem_instr;
        op_posted_q <= 1'b0;
      end else if (state_q == S_DATA && HREADY && okay && !last_sub) begin
        op_strb_q <= op_strb_q & ~cur_mask;
      end
      if (state_q == S_DATA && !HREADY && !okay) resp_err_q <= (HRESP == 2'b01);
      mem_ready_q <= push || ((op_done || err_done) && !op_posted_q);
      bus_err_q   <= err_done;
      if (op_done && !op_write_q) mem_rdata_q <= HRDATA;
      else if (err_done && !op_posted_q) mem_rdata_q <= '0;
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Entry storage is not reset; only the pointers and count define validity.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr[31:2];
      fifo_data_q[wr_ptr_q] <= mem_wdata;
      fifo_strb_q[wr_ptr_q] <= mem_wstrb;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_picorv_ahb_bridge.sv
// Directed bench for picorv_ahb_bridge: zero-wait reads, split writes, posted-write
// back-pressure, RETRY and ERROR responses, and reset in the middle of a transfer.
module tb_picorv_ahb_bridge;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready, bus_err;
  logic [31:0] mem_rdata;
  logic        HBUSREQ, HLOCK, HWRITE;
  logic        HGRANT = 1'b0, HREADY = 1'b1;
  logic [1:0]  HTRANS;
  logic [1:0]  HRESP = 2'b00;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA = 32'h0;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int checks = 0;
  int errors = 0;
  logic [39:0] alog[$];
  logic [31:0] wlog[$];
  logic        wr_pend = 1'b0;

  picorv_ahb_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(bus_err),
    .HBUSREQ(HBUSREQ), .HGRANT(HGRANT), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Log every accepted address phase and the write data of the following data phase.
  always @(negedge HCLK) begin
    if (wr_pend) wlog.push_back(HWDATA);
    wr_pend = 1'b0;
    if (!HRESET && HTRANS == 2'b10 && HREADY) begin
      alog.push_back({HPROT, HWRITE, HSIZE, HADDR});
      wr_pend = HWRITE;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ent(input logic [3:0] p, input logic w,
                                      input logic [2:0] s, input logic [31:0] a);
    return {p, w, s, a};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Wait up to maxc cycles for mem_ready; on success the CPU drops mem_valid the next cycle.
  task automatic cpu_wait(input int maxc, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = 32'h0;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (mem_ready) begin
        lat = i;
        rd  = mem_rdata;
        break;
      end
    end
    if (lat > 0) begin
      tick();
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
    end
  endtask

  task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int maxc, output int lat, output logic [31:0] rd);
    mem_valid = 1'b1;
    mem_instr = 1'b0;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    cpu_wait(maxc, lat, rd);
  endtask

  initial begin
    int lat, base, wbase, nready;
    logic [31:0] rd, tmpw;
    logic seen;

    #2 HRESET = 1'b1;
    repeat (3) tick();
    check_val("rst_busreq", 64'(HBUSREQ), 64'h0);
    check_val("rst_htrans", 64'(HTRANS), 64'h0);
    check_val("rst_ready_err", 64'({mem_ready, bus_err}), 64'h0);
    HRESET = 1'b0;
    tick();

    // 1: zero-wait word read
    HGRANT = 1'b1;
    HRDATA = 32'hDEADBEEF;
    base = alog.size();
    cpu_op(32'h100, 32'h0, 4'h0, 10, lat, rd);
    check_val("t1_latency", 64'(lat), 64'd4);
    check_val("t1_rdata", 64'(rd), 64'hDEADBEEF);
    check_val("t1_nxfer", 64'(alog.size() - base), 64'd1);
    check_val("t1_addrphase", 64'(alog[base]), 64'(ent(4'b0011, 1'b0, 3'b010, 32'h100)));
    check_val("t1_ready_pulse", 64'(mem_ready), 64'h0);

    // 2: strobe 0101 splits into two byte writes
    base = alog.size();
    wbase = wlog.size();
    cpu_op(32'h200, 32'h11223344, 4'b0101, 4, lat, rd);
    check_val("t2_posted_lat", 64'(lat), 64'd1);
    repeat (12) tick();
    check_val("t2_nxfer", 64'(alog.size() - base), 64'd2);
    check_val("t2_xfer0", 64'(alog[base]), 64'(ent(4'b0011, 1'b1, 3'b000, 32'h200)));
    check_val("t2_xfer1", 64'(alog[base + 1]), 64'(ent(4'b0011, 1'b1, 3'b000, 32'h202)));
    tmpw = wlog[wbase];
    check_val("t2_lane0", 64'(tmpw[7:0]), 64'h44);
    tmpw = wlog[wbase + 1];
    check_val("t2_lane2", 64'(tmpw[23:16]), 64'h22);

    // 3: FIFO back-pressure without grant, then a read behind the drained writes
    HGRANT = 1'b0;
    base = alog.size();
    cpu_op(32'h500, 32'hA0A0A0A0, 4'hF, 4, lat, rd);
    check_val("t3_w1_lat", 64'(lat), 64'd1);
    cpu_op(32'h504, 32'hB0B0B0B0, 4'hF, 4, lat, rd);
    check_val("t3_w2_lat", 64'(lat), 64'd1);
    cpu_op(32'h508, 32'hC0C0C0C0, 4'hF, 8, lat, rd);
    check_val("t3_w3_stalled", 64'(lat < 0), 64'h1);
    check_val("t3_busreq_wait", 64'(HBUSREQ), 64'h1);
    check_val("t3_no_xfer", 64'(alog.size() - base), 64'd0);
    HGRANT = 1'b1;
    cpu_wait(10, lat, rd);
    check_val("t3_w3_accepted", 64'(lat > 0), 64'h1);
    HRDATA = 32'h5A5A1234;
    cpu_op(32'h50C, 32'h0, 4'h0, 40, lat, rd);
    check_val("t3_rdata", 64'(rd), 64'h5A5A1234);
    check_val("t3_nxfer", 64'(alog.size() - base), 64'd4);
    check_val("t3_order0", 64'(alog[base]), 64'(ent(4'b0011, 1'b1, 3'b010, 32'h500)));
    check_val("t3_order1", 64'(alog[base + 1]), 64'(ent(4'b0011, 1'b1, 3'b010, 32'h504)));
    check_val("t3_order2", 64'(alog[base + 2]), 64'(ent(4'b0011, 1'b1, 3'b010, 32'h508)));
    check_val("t3_order3", 64'(alog[base + 3]), 64'(ent(4'b0011, 1'b0, 3'b010, 32'h50C)));

    // 4: RETRY on a read is reissued after re-requesting
    base = alog.size();
    mem_valid = 1'b1;
    mem_addr  = 32'h300;
    mem_wstrb = 4'h0;
    tick();
    tick();
    check_val("t4_nonseq", 64'(HTRANS), 64'h2);
    check_val("t4_addr", 64'(HADDR), 64'h300);
    tick();
    HREADY = 1'b0;
    HRESP  = 2'b10;
    tick();
    check_val("t4_idle_2nd", 64'(HTRANS), 64'h0);
    HREADY = 1'b1;
    tick();
    HRESP  = 2'b00;
    HRDATA = 32'hCAFEF00D;
    check_val("t4_rereq", 64'(HBUSREQ), 64'h1);
    check_val("t4_no_ready", 64'(mem_ready), 64'h0);
    cpu_wait(8, lat, rd);
    check_val("t4_rdata", 64'(rd), 64'hCAFEF00D);
    check_val("t4_nxfer", 64'(alog.size() - base), 64'd2);
    check_val("t4_reissue", 64'(alog[base + 1]), 64'(ent(4'b0011, 1'b0, 3'b010, 32'h300)));

    // 5a: ERROR on a read completes with zero data
    HRDATA = 32'hFFFFFFFF;
    mem_valid = 1'b1;
    mem_addr  = 32'h400;
    mem_wstrb = 4'h0;
    tick();
    tick();
    tick();
    HREADY = 1'b0;
    HRESP  = 2'b01;
    tick();
    HREADY = 1'b1;
    tick();
    HRESP = 2'b00;
    check_val("t5r_buserr", 64'(bus_err), 64'h1);
    check_val("t5r_ready", 64'(mem_ready), 64'h1);
    check_val("t5r_rdata", 64'(mem_rdata), 64'h0);
    tick();
    mem_valid = 1'b0;
    check_val("t5r_pulse_end", 64'({bus_err, mem_ready}), 64'h0);

    // 5b: ERROR on a posted write raises bus_err only
    mem_valid = 1'b1;
    mem_addr  = 32'h600;
    mem_wdata = 32'h66;
    mem_wstrb = 4'hF;
    tick();
    check_val("t5w_ack", 64'({mem_ready, bus_err}), 64'h2);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    tick();
    tick();
    check_val("t5w_addr", 64'({HWRITE, HADDR}), 64'h1_0000_0600);
    tick();
    HREADY = 1'b0;
    HRESP  = 2'b01;
    tick();
    HREADY = 1'b1;
    tick();
    HRESP = 2'b00;
    check_val("t5w_err_only", 64'({bus_err, mem_ready}), 64'h2);
    tick();
    check_val("t5w_pulse_end", 64'(bus_err), 64'h0);
    check_val("t5w_drained", 64'(HBUSREQ), 64'h0);

    // 6: reset during a data phase with two queued writes
    HGRANT = 1'b0;
    cpu_op(32'h700, 32'h77, 4'hF, 4, lat, rd);
    cpu_op(32'h704, 32'h88, 4'hF, 4, lat, rd);
    check_val("t6_w2_lat", 64'(lat), 64'd1);
    HGRANT = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (HTRANS == 2'b10) seen = 1'b1;
    end
    check_val("t6_addr_seen", 64'(seen), 64'h1);
    tick();
    check_val("t6_hwdata", 64'(HWDATA), 64'h77);
    HRESET = 1'b1;
    tick();
    check_val("t6_rst_bus", 64'({HBUSREQ, HTRANS, HWRITE, HSIZE, HPROT}), 64'h0);
    check_val("t6_rst_addr", 64'(HADDR), 64'h0);
    check_val("t6_rst_wdata", 64'(HWDATA), 64'h0);
    check_val("t6_rst_cpu", 64'({mem_ready, bus_err, mem_rdata}), 64'h0);
    HRESET = 1'b0;
    base = alog.size();
    nready = 0;
    repeat (10) begin
      tick();
      if (mem_ready) nready++;
    end
    check_val("t6_no_xfer", 64'(alog.size() - base), 64'd0);
    check_val("t6_no_ready", 64'(nready), 64'd0);
    check_val("t6_idle_busreq", 64'(HBUSREQ), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
